// File: rtl/mul_seq_core.sv
// mul_seq_core: sequential shift-add multiplier, one partial-product step per
// enabled clock, with a start/busy/done handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ena          clock enable; 0 holds every register
//   start        request, accepted only in IDLE
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   a, b         W-bit multiplicand / multiplier (sampled with start)
//   busy         high in RUN and DONE
//   done         one-cycle pulse, product valid while high
//   product      2*W-bit result, held until the next accepted start
module mul_seq_core #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int            CW    = $clog2(W + 1);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);
  localparam logic [W-1:0]  ONE_W = W'(1);
  localparam logic [2*W-1:0] ONE_P = {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_busy;
  logic            r_done;
  logic [2*W-1:0]  r_product;

  // Signed operands are reduced to magnitudes; -2^(W-1) negates to 2^(W-1),
  // which is still representable as a W-bit unsigned value.
  logic            w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [2*W-1:0]  w_acc_nxt, w_prod;

  assign w_a_neg   = signed_mode & a[W-1];
  assign w_b_neg   = signed_mode & b[W-1];
  assign w_a_mag   = w_a_neg ? (~a + ONE_W) : a;
  assign w_b_mag   = w_b_neg ? (~b + ONE_W) : b;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  // The last iteration's partial sum feeds the product directly so the result
  // lands on the same edge as the W-th step.
  assign w_prod    = r_neg ? (~w_acc_nxt + ONE_P) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {{W{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_product <= w_prod;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mul_seq_core.sv
module tb_mul_seq_core;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_run = 0;
  int n_fail = 0;

  mul_seq_core #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
    logic signed [2*W-1:0] s;
    logic [2*W-1:0] u;
    s = $signed(x) * $signed(y);
    u = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return sm ? 2*W'(0) | s : u;
  endfunction

  // One operation; lat = enabled+disabled edges from start edge (counted as 1)
  // until done is seen, -1 on timeout. Operands are scrambled after the start
  // edge to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                        input int ena_at, input int ena_len,
                        output logic [2*W-1:0] p, output int lat, output logic busy_ok);
    @(negedge clk);
    a = ia; b = ib; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; signed_mode = ~sm;
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 40) begin
      if (lat == ena_at) ena = 1'b0;
      if (lat == ena_at + ena_len) ena = 1'b1;
      @(negedge clk);
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    ena = 1'b1;
    p = product;
    if (!done) lat = -1;
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat, nd;
    logic bok;
    logic [W-1:0] ra, rb;
    logic rs;

    // 1 reset
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prod", 32'(product), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_prod", 32'(product), 0);

    // 2 unsigned max
    run_op(8'd255, 8'd255, 1'b0, -1, 0, p, lat, bok);
    chk("u255_prod", 32'(p), 32'hFE01);
    chk("u255_lat", 32'(lat), 9);
    chk("u255_busy", 32'(bok), 1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("hold_prod", 32'(product), 32'hFE01);
    @(negedge clk);
    chk("busy_clr", 32'(busy), 0);

    // 3 signed extremes
    run_op(8'h80, 8'h80, 1'b1, -1, 0, p, lat, bok);
    chk("s_m128xm128", 32'(p), 32'h4000);
    run_op(8'h80, 8'h01, 1'b1, -1, 0, p, lat, bok);
    chk("s_m128x1", 32'(p), 32'hFF80);
    run_op(8'h07, 8'hFD, 1'b1, -1, 0, p, lat, bok);
    chk("s_7xm3", 32'(p), 32'hFFEB);
    run_op(8'h00, 8'hFF, 1'b1, -1, 0, p, lat, bok);
    chk("s_0xm1", 32'(p), 32'h0000);
    chk("s_0xm1_lat", 32'(lat), 9);

    // 4a start re-pulsed during RUN is ignored
    @(negedge clk);
    a = 8'd3; b = 8'd5; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("repulse_ndone", 32'(nd), 1);
    chk("repulse_prod", 32'(product), 32'h000F);

    // 4b start held high: one op per IDLE visit
    @(negedge clk);
    a = 8'd2; b = 8'd3; start = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    start = 1'b0;
    chk("held_ndone", 32'(nd), 2);
    chk("held_prod", 32'(product), 32'h0006);
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(busy), 0);

    // 5 ena dropped for 4 cycles mid-RUN
    run_op(8'd200, 8'd3, 1'b0, 3, 4, p, lat, bok);
    chk("ena_prod", 32'(p), 32'h0258);
    chk("ena_lat", 32'(lat), 13);
    // freeze while in DONE keeps done high
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_done_hold", 32'(done), 1);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_done_rel", 32'(done), 0);

    // 6 reset mid-op
    @(negedge clk);
    a = 8'd50; b = 8'd50; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_prod", 32'(product), 0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mrst_nodone", 32'(nd), 0);
    run_op(8'd12, 8'd10, 1'b0, -1, 0, p, lat, bok);
    chk("mrst_next", 32'(p), 32'h0078);

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, -1, 0, p, lat, bok);
      if (lat < 0) chk("rnd_timeout", 32'(lat), 9);
      else chk($sformatf("rnd %0d a=%0h b=%0h s=%0d", i, ra, rb, rs), 32'(p),
               32'(ref_mul(ra, rb, rs)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
